// File: rtl/pipeline_pkg.sv
// Types and constants shared by the instruction-fetch front end.
// A fetch entry pairs a fetched instruction word with the PC it came from.
package pipeline_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of fetch entries with a flush input that empties it in one edge.
// The head entry is visible combinationally so the consumer can pop and use it in the same cycle.
module instr_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t pushData,
    output fetch_entry_t headData,
    output logic [PTR_W:0] count,
    output logic         empty,
    output logic         full
);

    fetch_entry_t    mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic            pushOk;
    logic            popOk;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign pushOk   = push && !full && !clear;
    assign popOk    = pop && !empty && !clear;
    assign headData = mem[rdPtr];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popOk) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushOk, popOk})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction-fetch front end: issues ROM reads ahead of ID, buffers returned words with their PCs,
// and feeds the IF/ID register; a taken branch flushes everything and redirects fetch.
module if_prefetch_buffer #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    rom_addr,
    output logic               rom_req,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               BranchTaken,
    input  logic [PC_W-1:0]    BranchTarget,
    input  logic               stall,
    output logic [INSTR_W-1:0] IF_ID_Instruction,
    output logic [PC_W-1:0]    IF_ID_PC,
    output logic               IF_ID_Valid
);

    import pipeline_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [PC_W-1:0]  fetchPc;
    logic [PC_W-1:0]  inflightPc;
    logic             inflightValid;
    logic [PTR_W:0]   fifoCount;
    logic [PTR_W:0]   occupancy;
    logic             fifoEmpty;
    logic             fifoFull;
    logic             fifoPush;
    logic             fifoPop;
    logic             romReq;
    fetch_entry_t     pushEntry;
    fetch_entry_t     headEntry;

    // Buffered plus outstanding words must fit, so a request is only made when a slot is reserved.
    assign occupancy = fifoCount + {{PTR_W{1'b0}}, inflightValid};
    assign romReq    = !BranchTaken && !fifoFull && (occupancy < (PTR_W+1)'(DEPTH));
    assign fifoPush  = inflightValid && !BranchTaken;
    assign fifoPop   = !BranchTaken && !stall && !fifoEmpty;

    assign pushEntry.instr = rom_data;
    assign pushEntry.pc    = inflightPc;

    assign rom_addr = fetchPc;
    assign rom_req  = romReq;

    instr_fifo #(
        .DEPTH(DEPTH)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifoPush),
        .pop      (fifoPop),
        .clear    (BranchTaken),
        .pushData (pushEntry),
        .headData (headEntry),
        .count    (fifoCount),
        .empty    (fifoEmpty),
        .full     (fifoFull)
    );

    // Fetch PC and in-flight tracking; a branch redirects and discards the pending return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc       <= RESET_PC;
            inflightValid <= 1'b0;
            inflightPc    <= '0;
        end else begin
            inflightValid <= romReq;
            if (romReq) begin
                inflightPc <= fetchPc;
            end
            if (BranchTaken) begin
                fetchPc <= BranchTarget;
            end else if (romReq) begin
                fetchPc <= fetchPc + 1'b1;
            end
        end
    end

    // IF/ID register: branch bubble beats stall hold, which beats popping the FIFO head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            IF_ID_Instruction <= NOP_INSTR;
            IF_ID_PC          <= '0;
            IF_ID_Valid       <= 1'b0;
        end else if (BranchTaken) begin
            IF_ID_Instruction <= NOP_INSTR;
            IF_ID_PC          <= '0;
            IF_ID_Valid       <= 1'b0;
        end else if (!stall) begin
            if (!fifoEmpty) begin
                IF_ID_Instruction <= headEntry.instr;
                IF_ID_PC          <= headEntry.pc;
                IF_ID_Valid       <= 1'b1;
            end else begin
                IF_ID_Instruction <= NOP_INSTR;
                IF_ID_PC          <= '0;
                IF_ID_Valid       <= 1'b0;
            end
        end
    end

endmodule
